// File: rtl/pc_regfile_if.sv
// rtl/pc_regfile_if.sv - bus bundle between the fetch/datapath master and pc_regfile
//
// Groups the PC control, register read ports and write port of pc_regfile.
//   master: drives pcread/pcenable/next_pc, read addresses and the write port,
//           observes pc/redirected/reg_out.
//   slave : the pc_regfile side of the same signals.
// Read ports are packed flat: port i uses rbank[i*BW +: BW], rreg[i*RW +: RW]
// and reg_out[i*XLEN +: XLEN].
interface pc_regfile_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NBANK = 2,
    parameter int NREAD = 2
);
    localparam int RW = $clog2(NREG);
    localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

    logic                  pcread;
    logic                  pcenable;
    logic [XLEN-1:0]       next_pc;
    logic [XLEN-1:0]       pc;
    logic                  redirected;
    logic [NREAD*BW-1:0]   rbank;
    logic [NREAD*RW-1:0]   rreg;
    logic [NREAD*XLEN-1:0] reg_out;
    logic                  wenable;
    logic [BW-1:0]         wbank;
    logic [RW-1:0]         wreg;
    logic [XLEN-1:0]       wdata;

    modport master (
        output pcread, pcenable, next_pc, rbank, rreg, wenable, wbank, wreg, wdata,
        input  pc, redirected, reg_out
    );

    modport slave (
        input  pcread, pcenable, next_pc, rbank, rreg, wenable, wbank, wreg, wdata,
        output pc, redirected, reg_out
    );
endinterface

// File: rtl/pc_regfile.sv
// rtl/pc_regfile.sv - program counter with replay guard plus banked multi-port register file
//
// Ports:
//   clk  - clock
//   rstn - synchronous active-low reset
//   bus  - pc_regfile_if.slave: pcread/pcenable/next_pc in, pc/redirected out,
//          NREAD registered read ports (rbank/rreg in, reg_out out),
//          one write port (wenable/wbank/wreg/wdata).
// The register array itself is not reset; hardwired-zero registers and
// out-of-range banks always read as zero.
module pc_regfile #(
    parameter int              XLEN      = 32,
    parameter int              NREG      = 32,
    parameter int              NBANK     = 2,
    parameter int              NREAD     = 2,
    parameter int              HIST      = 2,
    parameter logic [NBANK-1:0] ZERO_MASK = NBANK'(1),
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic         clk,
    input  logic         rstn,
    pc_regfile_if.slave  bus
);
    localparam int RW  = $clog2(NREG);
    localparam int BW  = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int NBX = 1 << BW;

    // Zero mask widened to every encodable bank so it can be indexed by any
    // bank select without going out of range.
    localparam logic [NBX-1:0] ZMASK   = NBX'(ZERO_MASK);
    localparam logic [BW:0]    NBANK_W = (BW+1)'(NBANK);

    function automatic logic bank_ok(input logic [BW-1:0] b);
        return {1'b0, b} < NBANK_W;
    endfunction

    function automatic logic is_zero(input logic [BW-1:0] b, input logic [RW-1:0] r);
        return ZMASK[b] && (r == '0);
    endfunction

    // ---------------------------------------------------------------- PC path
    logic [XLEN-1:0]           pc_q, pc_d;
    logic [HIST-1:0][XLEN-1:0] hist_q, hist_d;
    logic [HIST-1:0]           hv_q, hv_d;
    logic                      redirected_q, redirected_d;
    logic                      take;

    always_comb begin
        // A redirect back to the PC fetched HIST advances ago is a replay and is dropped.
        take         = bus.pcenable && !(hv_q[HIST-1] && (hist_q[HIST-1] == bus.next_pc));
        pc_d         = pc_q;
        hist_d       = hist_q;
        hv_d         = hv_q;
        redirected_d = take;
        if (take) begin
            pc_d = bus.next_pc;
            hv_d = '0;
        end else if (bus.pcread) begin
            pc_d      = pc_q + XLEN'(4);
            hist_d[0] = pc_q;
            hv_d[0]   = 1'b1;
            for (int k = 1; k < HIST; k++) begin
                hist_d[k] = hist_q[k-1];
                hv_d[k]   = hv_q[k-1];
            end
        end
    end

    // ---------------------------------------------------------- register file
    logic [XLEN-1:0]             regs_q [NBANK][NREG];
    logic [NREAD-1:0][BW-1:0]    rb;
    logic [NREAD-1:0][RW-1:0]    rr;
    logic [NREAD-1:0][XLEN-1:0]  reg_out_q, reg_out_d;
    logic                        wr_en;

    assign rb = bus.rbank;
    assign rr = bus.rreg;

    always_comb begin
        wr_en = bus.wenable && bank_ok(bus.wbank) && !is_zero(bus.wbank, bus.wreg);
    end

    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            reg_out_d[i] = '0;
            if (bank_ok(rb[i]) && !is_zero(rb[i], rr[i])) begin
                // Same-cycle write to the addressed register is forwarded.
                if (bus.wenable && (bus.wbank == rb[i]) && (bus.wreg == rr[i])) begin
                    reg_out_d[i] = bus.wdata;
                end else begin
                    reg_out_d[i] = regs_q[rb[i]][rr[i]];
                end
            end
        end
    end

    // -------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q         <= RESET_PC;
            hist_q       <= '0;
            hv_q         <= '0;
            redirected_q <= 1'b0;
            reg_out_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            hist_q       <= hist_d;
            hv_q         <= hv_d;
            redirected_q <= redirected_d;
            reg_out_q    <= reg_out_d;
        end
    end

    // Array contents survive reset; only a write coincident with reset is dropped.
    always_ff @(posedge clk) begin
        if (rstn && wr_en) begin
            regs_q[bus.wbank][bus.wreg] <= bus.wdata;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.redirected = redirected_q;
    assign bus.reg_out    = reg_out_q;
endmodule

// File: tb/tb_pc_regfile.sv
// tb/tb_pc_regfile.sv - self-checking bench for pc_regfile against a queue/array reference model
module tb_pc_regfile;
    localparam int HIST = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    pc_regfile_if #(.XLEN(32), .NREG(32), .NBANK(3), .NREAD(3)) bus ();
    pc_regfile_if bus2 ();

    pc_regfile #(.XLEN(32), .NREG(32), .NBANK(3), .NREAD(3), .HIST(HIST),
                 .ZERO_MASK(3'b001), .RESET_PC(32'h0)) dut (
        .clk(clk), .rstn(rstn), .bus(bus));

    pc_regfile #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rstn(rstn), .bus(bus2));

    int checks   = 0;
    int failures = 0;

    // Reference model: pc, fetch history as a queue (front = newest),
    // register contents with a written flag, expected read data per port.
    logic [31:0] m_pc;
    logic [31:0] m_hist [$];
    logic        m_redir;
    logic [31:0] m_rout [3];
    bit          m_rk   [3];
    logic [31:0] mem    [3][32];
    bit          mk     [3][32];

    task automatic set_idle();
        bus.pcread = 0; bus.pcenable = 0; bus.next_pc = 0;
        bus.rbank = 0; bus.rreg = 0;
        bus.wenable = 0; bus.wbank = 0; bus.wreg = 0; bus.wdata = 0;
        bus2.pcread = 0; bus2.pcenable = 0; bus2.next_pc = 0;
        bus2.rbank = 0; bus2.rreg = 0;
        bus2.wenable = 0; bus2.wbank = 0; bus2.wreg = 0; bus2.wdata = 0;
    endtask

    task automatic set_read(input int p, input int b, input int r);
        bus.rbank[p*2 +: 2] = 2'(b);
        bus.rreg[p*5 +: 5]  = 5'(r);
    endtask

    task automatic set_write(input int b, input int r, input logic [31:0] d);
        bus.wenable = 1;
        bus.wbank   = 2'(b);
        bus.wreg    = 5'(r);
        bus.wdata   = d;
    endtask

    // Advance the model from the current inputs, then take one clock edge.
    task automatic cycle();
        int  b, r, wb, wr;
        bit  take;
        if (!rstn) begin
            m_pc = 32'h0;
            m_hist.delete();
            m_redir = 0;
            for (int i = 0; i < 3; i++) begin m_rout[i] = 0; m_rk[i] = 1; end
        end else begin
            wb = int'(bus.wbank);
            wr = int'(bus.wreg);
            for (int i = 0; i < 3; i++) begin
                b = int'(bus.rbank[i*2 +: 2]);
                r = int'(bus.rreg[i*5 +: 5]);
                if (b >= 3 || (b == 0 && r == 0)) begin
                    m_rout[i] = 0; m_rk[i] = 1;
                end else if (bus.wenable && wb == b && wr == r) begin
                    m_rout[i] = bus.wdata; m_rk[i] = 1;
                end else begin
                    m_rout[i] = mem[b][r]; m_rk[i] = mk[b][r];
                end
            end
            take = bus.pcenable &&
                   !(m_hist.size() == HIST && m_hist[HIST-1] == bus.next_pc);
            if (take) begin
                m_pc = bus.next_pc;
                m_hist.delete();
            end else if (bus.pcread) begin
                m_hist.push_front(m_pc);
                if (m_hist.size() > HIST) void'(m_hist.pop_back());
                m_pc = m_pc + 32'd4;
            end
            m_redir = take;
            if (bus.wenable && wb < 3 && !(wb == 0 && wr == 0)) begin
                mem[wb][wr] = bus.wdata;
                mk[wb][wr]  = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rstn = 0;
        cycle();
        rstn = 1;
    endtask

    task automatic test_reset();
        set_idle();
        rstn = 0;
        bus.pcread = 1;
        set_write(0, 5, 32'hAA);
        for (int p = 0; p < 3; p++) set_read(p, 0, 5);
        repeat (3) cycle();
        checks++;
        if (bus.pc !== 32'h0) begin failures++; $display("FAIL reset_pc actual=%h expected=%h", bus.pc, 32'h0); end
        checks++;
        if (bus.redirected !== 1'b0) begin failures++; $display("FAIL reset_redirected actual=%b expected=0", bus.redirected); end
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (bus.reg_out[p*32 +: 32] !== 32'h0) begin
                failures++; $display("FAIL reset_reg_out%0d actual=%h expected=0", p, bus.reg_out[p*32 +: 32]);
            end
        end
        checks++;
        if (bus2.pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL reset_pc_wrapdut actual=%h expected=fffffffc", bus2.pc); end
        rstn = 1;
        set_idle();
        set_read(0, 0, 5);
        cycle();
        checks++;
        if (bus.reg_out[31:0] === 32'hAA) begin failures++; $display("FAIL reset_write_dropped actual=%h expected=not aa", bus.reg_out[31:0]); end
        checks++;
        if (bus.pc !== m_pc) begin failures++; $display("FAIL reset_pc_hold actual=%h expected=%h", bus.pc, m_pc); end
    endtask

    task automatic test_fetch();
        set_idle();
        bus.pcread = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (bus.pc !== m_pc || bus.pc !== 32'(4*(k+1))) begin
                failures++; $display("FAIL fetch_pc%0d actual=%h expected=%h", k, bus.pc, m_pc);
            end
        end
        set_idle();
        bus2.pcread = 1;
        cycle();
        checks++;
        if (bus2.pc !== 32'h0) begin failures++; $display("FAIL fetch_wrap actual=%h expected=0", bus2.pc); end
    endtask

    task automatic test_redirect();
        do_reset();
        bus.pcread = 1;
        repeat (2) cycle();
        bus.pcenable = 1;
        bus.next_pc  = 32'h0;
        cycle();
        checks++;
        if (bus.pc !== m_pc || bus.pc !== 32'hC) begin failures++; $display("FAIL redir_suppressed_pc actual=%h expected=%h", bus.pc, m_pc); end
        checks++;
        if (bus.redirected !== 1'b0) begin failures++; $display("FAIL redir_suppressed_flag actual=%b expected=0", bus.redirected); end
        bus.pcread  = 0;
        bus.next_pc = 32'h100;
        cycle();
        checks++;
        if (bus.pc !== 32'h100 || bus.redirected !== 1'b1) begin
            failures++; $display("FAIL redir_taken actual=%h/%b expected=00000100/1", bus.pc, bus.redirected);
        end
        cycle();
        checks++;
        if (bus.pc !== m_pc || bus.redirected !== m_redir || m_redir !== 1'b1) begin
            failures++; $display("FAIL redir_again actual=%h/%b expected=%h/%b", bus.pc, bus.redirected, m_pc, m_redir);
        end
        bus.pcenable = 0;
        cycle();
        checks++;
        if (bus.redirected !== 1'b0) begin failures++; $display("FAIL redir_pulse_end actual=%b expected=0", bus.redirected); end
    endtask

    task automatic test_banks();
        set_idle(); set_write(0, 0, 32'h55); cycle();
        set_idle(); set_write(1, 0, 32'h66); cycle();
        set_idle(); set_write(2, 3, 32'h77); cycle();
        set_idle();
        set_read(0, 0, 0); set_read(1, 1, 0); set_read(2, 2, 3);
        cycle();
        checks++;
        if (bus.reg_out[31:0] !== 32'h0) begin failures++; $display("FAIL bank0_r0 actual=%h expected=0", bus.reg_out[31:0]); end
        checks++;
        if (bus.reg_out[63:32] !== 32'h66) begin failures++; $display("FAIL bank1_r0 actual=%h expected=66", bus.reg_out[63:32]); end
        checks++;
        if (bus.reg_out[95:64] !== 32'h77) begin failures++; $display("FAIL bank2_r3 actual=%h expected=77", bus.reg_out[95:64]); end
        set_idle();
        set_write(3, 1, 32'h99);
        set_read(0, 3, 1);
        set_read(1, 3, 0);
        cycle();
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (bus.reg_out[p*32 +: 32] !== 32'h0) begin
                failures++; $display("FAIL bank3_port%0d actual=%h expected=0", p, bus.reg_out[p*32 +: 32]);
            end
        end
    endtask

    task automatic test_bypass();
        set_idle();
        set_write(1, 7, 32'h1234);
        for (int p = 0; p < 3; p++) set_read(p, 1, 7);
        cycle();
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (bus.reg_out[p*32 +: 32] !== 32'h1234) begin
                failures++; $display("FAIL bypass_port%0d actual=%h expected=1234", p, bus.reg_out[p*32 +: 32]);
            end
        end
        set_idle();
        set_write(0, 0, 32'hDEAD);
        for (int p = 0; p < 3; p++) set_read(p, 0, 0);
        cycle();
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (bus.reg_out[p*32 +: 32] !== 32'h0) begin
                failures++; $display("FAIL bypass_zero_port%0d actual=%h expected=0", p, bus.reg_out[p*32 +: 32]);
            end
        end
        set_idle();
        set_read(2, 1, 7);
        cycle();
        checks++;
        if (bus.reg_out[95:64] !== 32'h1234) begin failures++; $display("FAIL bypass_committed actual=%h expected=1234", bus.reg_out[95:64]); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.pcread = 1;
        repeat (3) cycle();
        bus.pcenable = 1;
        bus.next_pc  = 32'h40;
        set_write(2, 9, 32'hBEEF);
        cycle();
        checks++;
        if (bus.pc !== 32'h40 || bus.redirected !== 1'b1) begin
            failures++; $display("FAIL simul_redirect actual=%h/%b expected=00000040/1", bus.pc, bus.redirected);
        end
        // Had the history shifted instead of clearing, hist[1] would hold 8 and this would be suppressed.
        set_idle();
        bus.pcenable = 1;
        bus.next_pc  = 32'h8;
        set_read(0, 2, 9);
        cycle();
        checks++;
        if (bus.pc !== m_pc || bus.pc !== 32'h8) begin failures++; $display("FAIL simul_hist_cleared actual=%h expected=%h", bus.pc, m_pc); end
        checks++;
        if (bus.reg_out[31:0] !== 32'hBEEF) begin failures++; $display("FAIL simul_write actual=%h expected=beef", bus.reg_out[31:0]); end
    endtask

    task automatic test_random();
        set_idle();
        for (int n = 0; n < 400; n++) begin
            rstn         = ($urandom_range(0, 40) != 0);
            bus.pcread   = 1'($urandom_range(0, 1));
            bus.pcenable = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1 && m_hist.size() == HIST)
                bus.next_pc = m_hist[HIST-1];
            else
                bus.next_pc = $urandom & 32'hFFFF_FFFC;
            bus.wenable = 1'($urandom_range(0, 1));
            bus.wbank   = 2'($urandom_range(0, 3));
            bus.wreg    = 5'($urandom_range(0, 7));
            bus.wdata   = $urandom;
            for (int p = 0; p < 3; p++) set_read(p, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
            cycle();
            checks++;
            if (bus.pc !== m_pc || bus.redirected !== m_redir) begin
                failures++; $display("FAIL rand_pc n=%0d actual=%h/%b expected=%h/%b", n, bus.pc, bus.redirected, m_pc, m_redir);
            end
            for (int p = 0; p < 3; p++) begin
                if (m_rk[p]) begin
                    checks++;
                    if (bus.reg_out[p*32 +: 32] !== m_rout[p]) begin
                        failures++; $display("FAIL rand_read n=%0d port=%0d actual=%h expected=%h", n, p, bus.reg_out[p*32 +: 32], m_rout[p]);
                    end
                end
            end
        end
        rstn = 1;
    endtask

    initial begin
        rstn = 0;
        set_idle();
        test_reset();
        test_fetch();
        test_redirect();
        test_banks();
        test_bypass();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_regfile.md
# pc_regfile

Parametrised program-counter and banked register-file unit for the core datapath. It holds the fetch PC and its redirect/replay guard, plus NBANK register banks with NREAD registered read ports and one write port. Compared with the fixed two-bank, two-port, 32-bit unit, it adds:
- configurable width, register count, bank count, port count and history depth;
- write-to-read bypass;
- per-bank hardwired-zero selection;
- valid-tracked PC history and a redirect-taken indication.

## Interface
Parameters:
- XLEN, 32, data and PC width
- NREG, 32, registers per bank (power of two, ≥2); RW = $clog2(NREG)
- NBANK, 2, number of banks (≥1); BW = max(1, $clog2(NBANK))
- NREAD, 2, read ports (≥1)
- HIST, 2, PC history depth (≥1)
- ZERO_MASK, NBANK'b1, bit b set: register 0 of bank b is hardwired zero
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-low.
- rstn  in  1  synchronous active-low reset
- pcread  in  1  advance PC by 4
- pcenable  in  1  request redirect to next_pc
- next_pc  in  XLEN  redirect target
- pc  out  XLEN  current PC (registered)
- redirected  out  1  one-cycle pulse: a redirect was taken on the previous edge
- rbank  in  NREAD*BW  per-port bank select; port i uses bits [i*BW +: BW]
- rreg  in  NREAD*RW  per-port register index
- reg_out  out  NREAD*XLEN  per-port read data (registered)
- wenable  in  1  write strobe
- wbank  in  BW  write bank
- wreg  in  RW  write index
- wdata  in  XLEN  write data

## Operation
- **PC history:** HIST entries hist[0..HIST-1], each with a valid bit. hist[0] is the newest entry.
- **Redirect taken:** `take = pcenable && !(hv[HIST-1] && hist[HIST-1] == next_pc)`.
  - The condition suppresses a redirect that would replay the PC from HIST fetches ago.
- **PC update priority:**
  1. If `take`: pc ← next_pc; all history valids cleared.
  2. Else if `pcread`: pc ← pc + 4, modulo 2^XLEN. The history shifts and takes in the old pc: hist[0] ← pc, hv[0] ← 1, hist[k] ← hist[k-1].
  3. Else: hold.
- **Suppressed redirect:** when pcenable is high but `take` is 0, the cycle behaves as if pcenable were low. pcread still applies.
- **redirected:** registered copy of `take`.
- **Writes:**
  - When wenable is high and not in reset, bank[wbank][wreg] ← wdata.
  - A write to register 0 of a ZERO_MASK bank is discarded.
  - A write with wbank ≥ NBANK is discarded.
- **Reads, per port i:**
  - The addressed value is sampled each edge into reg_out[i].
  - Out-of-range bank or a hardwired-zero register reads 0.
- **Bypass:** if wenable is high and (wbank, wreg) equals port i's address in the same cycle, reg_out[i] ← wdata. The exception is a hardwired-zero target, which gives 0.
  - All ports may match the same write at once.
- **Register contents:** not reset, undefined until written. Hardwired-zero registers always read 0.

## Timing
- **Reset** (rstn=0 at edge):
  - pc ← RESET_PC; all hv ← 0; redirected ← 0; all reg_out ← 0.
  - Writes and reads are ignored; pcread and pcenable are ignored.
- **Reset mid-operation:** takes effect at that edge and discards a coincident write or redirect. Register contents other than that write are retained.
- **Read latency:** 1 cycle. Address at edge n gives data valid after edge n.
- **Write latency:**
  - Written data is visible through the array to a read issued the following cycle.
  - A same-cycle read gets it via bypass.
- **Redirect:** pc = next_pc after the edge where `take` is sampled. redirected is high for the following cycle only.
- **Simultaneous pcenable and pcread:** redirect wins when taken, and the history is cleared rather than shifted.
- **After a redirect:** replay suppression needs HIST pcread advances to refill hist[HIST-1]. Until then every pcenable is taken.

## Test plan
- **Reset:** hold rstn=0 with pcread=1, wenable=1, wreg=5, wdata=0xAA → after release pc=0, reg_out=0, redirected=0, and a read of bank0 r5 does not return 0xAA.
- **Sequential fetch and wrap:** pcread=1 for 3 cycles → pc 0,4,8,12. With XLEN=32 and RESET_PC=0xFFFFFFFC, one pcread → pc=0.
- **Redirect and suppression (HIST=2):**
  - Fetch to pc=8 (history 4,0), then pcenable with next_pc=0 → suppressed, pc=0xC, redirected=0.
  - Then next_pc=0x100 → pc=0x100, redirected pulses once.
  - An immediate pcenable with next_pc=0x100 is taken, because the history is invalid.
- **Banks and zero register (ZERO_MASK=01):**
  - Write bank0 r0=0x55 and bank1 r0=0x66, then read both → 0 and 0x66.
  - Read bank 2 with NBANK=3 after writing 0x77 → 0x77. A read of bank 3 → 0.
- **Bypass, all ports (NREAD=3):** write bank1 r7=0x1234 while all ports read bank1 r7 → all reg_out=0x1234 next cycle. Write bank0 r0 with bypass → 0.
- **Simultaneous events:** pcenable (taken, next_pc=0x40) with pcread=1 and a write in the same cycle → pc=0x40, history cleared, write committed.
